mips_test_sequencer: RTL
========================

MIPS_TEST_SEQUENCER -- requirements
Module: mips_test_sequencer

Interface
REQ-001 SHALL have parameter WIDTH, default 32, meaning the data/instruction/compare width.
REQ-002 SHALL have parameter DEPTH, default 16, meaning the number of vector entries (power of two, ≥2).
REQ-003 SHALL have parameter RST_CYCLES, default 2, meaning the number of cycles the core under test is held in reset before the run.
REQ-004 SHALL have ports clk in 1 (the single clock) and reset in 1 (asynchronous, active-high reset).
REQ-005 SHALL have load_valid in 1, load_ready out 1, load_instr in WIDTH, load_rdata in WIDTH, load_expect in WIDTH, and load_mode in 2, forming the vector-append handshake.
REQ-006 SHALL have start in 1 (begin run), abort in 1 (stop run), and clear in 1 (empty the table).
REQ-007 SHALL have dut_reset out 1, instr out WIDTH, and readdata out WIDTH, which drive the core.
REQ-008 SHALL have pc in WIDTH, aluout in WIDTH, writedata in WIDTH, and memwrite in 1, which are observed from the core.
REQ-009 SHALL have busy out 1, done out 1, pass_count out log2(DEPTH)+1, fail_count out log2(DEPTH)+1, fail_seen out 1, and first_fail_idx out log2(DEPTH).

Function
REQ-010 SHALL implement the FSM states IDLE, DUTRST, RUN, and DONE.
REQ-011 SHALL raise load_ready only in IDLE or DONE while the stored entry count is below DEPTH; an entry is appended on the cycle load_valid and load_ready are both high.
REQ-012 SHALL hold load_ready low when the table is full (count==DEPTH) and ignore load_valid.
REQ-013 SHALL zero the entry count on clear in IDLE/DONE; clear in DUTRST/RUN SHALL be ignored; clear and load in the same cycle SHALL leave count=0 (clear wins).
REQ-014 SHALL, on start in IDLE/DONE: zero the counters and fail_seen, deassert done, and go to DUTRST; start in other states SHALL be ignored.
REQ-015 SHALL keep the core in reset during DUTRST, with dut_reset=1 for exactly RST_CYCLES cycles, then go to RUN with index 0; dut_reset=0 in all other states.
REQ-016 SHALL, if the count is 0 at entry to RUN, go to DONE on the next edge with both counts 0.
REQ-017 SHALL, in RUN, drive instr and readdata from entry[index] during the whole cycle; at the closing edge it compares, updates counters and increments index: one vector per cycle, throughput 1.
REQ-018 SHALL apply the comparison selected by mode: 00 = no check (counts as pass); 01 = aluout==expect; 10 = memwrite==1 and writedata==expect; 11 = pc==expect. Compares are full-WIDTH and unsigned.
REQ-019 SHALL increment pass_count on a passing check and fail_count otherwise; the first failure sets fail_seen=1 and latches first_fail_idx, and later failures do not change it.
REQ-020 SHALL go to DONE after the entry at index count-1 is checked, with done=1 held until the next start or reset; index does not wrap.
REQ-021 SHALL, on abort in DUTRST/RUN, go to IDLE with done=0; counters retain partial values, and the table is preserved.
REQ-022 SHALL drive busy=1 exactly in DUTRST and RUN; in IDLE/DONE, instr=0 and readdata=0.

Reset
REQ-023 SHALL set, while reset is asserted: state IDLE, count 0, index 0, all counters 0, fail_seen 0, first_fail_idx 0, done 0, busy 0, load_ready 1, dut_reset 1, instr 0, readdata 0.
REQ-024 SHALL respond to reset assertion mid-run immediately (asynchronously), discarding the table.
REQ-025 SHALL leave the table contents (RAM) uninitialised on reset; only the count is cleared.

Structure
REQ-026 SHALL place the check-mode encodings (CHK_NONE, CHK_ALU, CHK_STORE, CHK_PC) and the FSM state encodings in the shared package mips_pkg.
REQ-027 SHALL store vectors in sub-module mips_vec_ram: DEPTH x (2*WIDTH+WIDTH+2), one write port, and an asynchronous read port indexed by the run index.

Verification
REQ-028 SHALL cover: load {ADDI R2,R1,8 = 0x20220008, mode 01, expect 8}, start, with a core that returns aluout=8 -> after 2+1 cycles done=1, pass=1, fail=0.
REQ-029 SHALL cover: three entries, with entry 1 expect 16 and the core returning 17 -> pass=2, fail=1, fail_seen=1, first_fail_idx=1.
REQ-030 SHALL cover: 17 load attempts at DEPTH=16 -> load_ready drops after the 16th handshake, count=16, and the 17th is not stored.
REQ-031 SHALL cover: start with an empty table -> DUTRST for 2 cycles, RUN 1 cycle, then done=1, pass=0, fail=0.
REQ-032 SHALL cover: assert reset during RUN at index 3 -> same cycle state IDLE, dut_reset=1, busy=0, counts 0; load_ready=1 after release.
REQ-033 SHALL cover: Jump 4 (0x08000004, mode 11, expect 0x10), then abort during a second run -> pass=1 from the first run; the abort yields IDLE, done=0, and the table count is unchanged.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared encodings for the MIPS test sequencer.
// FSM states and per-vector check modes.
package mips_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DUTRST = 2'd1,
        RUN    = 2'd2,
        DONE   = 2'd3
    } state_t;

    localparam logic [1:0] CHK_NONE  = 2'b00;
    localparam logic [1:0] CHK_ALU   = 2'b01;
    localparam logic [1:0] CHK_STORE = 2'b10;
    localparam logic [1:0] CHK_PC    = 2'b11;

endpackage

// File: rtl/mips_vec_ram.sv
// Test-vector table: one write port, async read by run index.
// Contents are deliberately left unreset.
module mips_vec_ram
    import mips_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 16,
    localparam int AW = $clog2(DEPTH),
    localparam int EW = 3 * WIDTH + 2
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [EW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [EW-1:0] rdata
);

    logic [EW-1:0] mem [DEPTH];

    // Append one vector per accepted handshake
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/mips_test_sequencer.sv
// Feeds stored instruction vectors to a MIPS core under test,
// one per cycle, and scores the core's responses.
module mips_test_sequencer
    import mips_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 16,
    parameter int RST_CYCLES = 2,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [WIDTH-1:0] load_instr,
    input  logic [WIDTH-1:0] load_rdata,
    input  logic [WIDTH-1:0] load_expect,
    input  logic [1:0]       load_mode,
    input  logic             start,
    input  logic             abort,
    input  logic             clear,
    output logic             dut_reset,
    output logic [WIDTH-1:0] instr,
    output logic [WIDTH-1:0] readdata,
    input  logic [WIDTH-1:0] pc,
    input  logic [WIDTH-1:0] aluout,
    input  logic [WIDTH-1:0] writedata,
    input  logic             memwrite,
    output logic             busy,
    output logic             done,
    output logic [AW:0]      pass_count,
    output logic [AW:0]      fail_count,
    output logic             fail_seen,
    output logic [AW-1:0]    first_fail_idx
);

    localparam int EW = 3 * WIDTH + 2;
    localparam int RW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
    localparam logic [RW-1:0] RLAST = RW'(RST_CYCLES - 1);
    localparam logic [RW-1:0] R1 = RW'(1);
    localparam logic [AW:0] FULL = (AW + 1)'(DEPTH);
    localparam logic [AW:0] C1 = (AW + 1)'(1);
    localparam logic [AW-1:0] I1 = AW'(1);

    state_t state, state_n;

    logic [AW:0]       count;
    logic [AW-1:0]     idx;
    logic [RW-1:0]     rcnt;
    logic [EW-1:0]     rd;
    logic [WIDTH-1:0]  v_instr, v_rdata, v_exp;
    logic [1:0]        v_mode;
    logic              idle_like, push, empty, last, hit;

    assign idle_like = (state == IDLE) || (state == DONE);
    assign push      = load_valid && load_ready && !clear;
    assign empty     = (count == '0);
    assign last      = ({1'b0, idx} == (count - C1));

    mips_vec_ram #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_ram (
        .clk   (clk),
        .we    (push),
        .waddr (count[AW-1:0]),
        .wdata ({load_instr, load_rdata, load_expect, load_mode}),
        .raddr (idx),
        .rdata (rd)
    );

    assign {v_instr, v_rdata, v_exp, v_mode} = rd;

    // Score the current vector against the core's outputs
    always_comb begin
        hit = 1'b1;
        unique case (v_mode)
            CHK_NONE:  hit = 1'b1;
            CHK_ALU:   hit = (aluout == v_exp);
            CHK_STORE: hit = memwrite && (writedata == v_exp);
            CHK_PC:    hit = (pc == v_exp);
        endcase
    end

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_n;
    end

    // Next-state: abort beats run progress, empty table ends at once
    always_comb begin
        state_n = state;
        case (state)
            IDLE, DONE: if (start) state_n = DUTRST;
            DUTRST: begin
                if (abort)              state_n = IDLE;
                else if (rcnt == RLAST) state_n = RUN;
            end
            RUN: begin
                if (abort)              state_n = IDLE;
                else if (empty || last) state_n = DONE;
            end
            default: state_n = IDLE;
        endcase
    end

    // Outputs; vectors only reach the core while running
    always_comb begin
        busy       = (state == DUTRST) || (state == RUN);
        done       = (state == DONE);
        dut_reset  = reset || (state == DUTRST);
        load_ready = idle_like && (count != FULL);
        instr      = '0;
        readdata   = '0;
        if (state == RUN && !empty) begin
            instr    = v_instr;
            readdata = v_rdata;
        end
    end

    // Table count, run index, reset timer and scoreboard
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count          <= '0;
            idx            <= '0;
            rcnt           <= '0;
            pass_count     <= '0;
            fail_count     <= '0;
            fail_seen      <= 1'b0;
            first_fail_idx <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (clear)     count <= '0;
                    else if (push) count <= count + C1;
                    if (start) begin
                        pass_count     <= '0;
                        fail_count     <= '0;
                        fail_seen      <= 1'b0;
                        first_fail_idx <= '0;
                        rcnt           <= '0;
                    end
                end
                DUTRST: begin
                    if (!abort) begin
                        rcnt <= rcnt + R1;
                        idx  <= '0;
                    end
                end
                RUN: begin
                    if (!abort && !empty) begin
                        if (hit) begin
                            pass_count <= pass_count + C1;
                        end else begin
                            fail_count <= fail_count + C1;
                            if (!fail_seen) begin
                                fail_seen      <= 1'b1;
                                first_fail_idx <= idx;
                            end
                        end
                        if (!last) idx <= idx + I1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
